midi_msg_decoder: RTL and testbench

- Parametrised MIDI byte-stream decoder; successor of the single-message MIDI command decoder.
- Takes bytes from the UART receiver and assembles complete channel-voice messages.
- Supports running status, interleaved real-time bytes, SysEx skipping and a per-channel accept mask.
- Queues decoded messages in a FIFO with a valid/ready handshake toward the voice allocator.

---
 rtl/midi_msg_decoder.sv | 188 ++++++++++++++++++
 tb/tb_midi_msg_decoder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/midi_msg_decoder.sv
// midi_msg_decoder: MIDI byte stream -> queued channel-voice messages.
// Latency: final data byte sampled at edge N appears on m_valid/m_* after edge N.
// Backpressure: m_ready stalls the FIFO head; completed messages arriving while
//   the FIFO is full (and not popping) are dropped and counted in drop_cnt.
// Ports: clk/rst (sync, active-high); valid_byte/data byte input;
//   m_valid/m_ready/m_type/m_channel/m_data1/m_data2 message output;
//   fifo_count occupancy; rst_cmd one-cycle pulse after 8'hFF; drop_cnt.
// Optional macro MIDI_RUNNING_STATUS_EN: keep the status after a completed
//   message so further data bytes start a new message with it.

// Generic first-word fall-through FIFO; head read combinationally.
module midi_msg_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_vld,
   output logic                     wr_rdy,
   input  logic [W-1:0]             wr_dat,
   output logic                     rd_vld,
   input  logic                     rd_rdy,
   output logic [W-1:0]             rd_dat,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push;
   logic          pop;

   assign rd_vld = (count != '0);
   assign pop    = rd_vld && rd_rdy;
   // A pop in the same cycle frees a slot, so a full FIFO still accepts.
   assign wr_rdy = (count != DEPTH_C) || pop;
   assign push   = wr_vld && wr_rdy;
   // Head forced to zero while empty so the output fields read 0 after reset.
   assign rd_dat = rd_vld ? mem[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_dat;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end
endmodule

module midi_msg_decoder #(
   parameter int          DEPTH   = 8,
   parameter logic [15:0] CH_MASK = 16'hFFFF,
   parameter int          CNT_W   = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     valid_byte,
   input  logic [7:0]               data,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [2:0]               m_type,
   output logic [3:0]               m_channel,
   output logic [6:0]               m_data1,
   output logic [6:0]               m_data2,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     rst_cmd,
   output logic [CNT_W-1:0]         drop_cnt
);
   typedef enum logic [2:0] {IDLE, D1, D2, SYSEX, SKIP} state_t;

`ifdef MIDI_RUNNING_STATUS_EN
   localparam state_t AFTER_MSG = D1;
`else
   localparam state_t AFTER_MSG = IDLE;
`endif

   state_t     state;
   logic [7:0] status;     // current / running status byte, 0 when cleared
   logic [6:0] d1_q;
   logic [1:0] skip_cnt;

   logic        is_rt;
   logic        is_status;
   logic        is_data;
   logic        two_byte;
   logic        msg_done;
   logic [20:0] msg_dat;
   logic [20:0] head_dat;
   logic        fifo_rdy;
   logic        accept;

   assign is_rt     = valid_byte && (data >= 8'hF8);
   assign is_status = valid_byte && data[7] && !is_rt;
   assign is_data   = valid_byte && !data[7];
   // Cx (program change) and Dx (channel pressure) carry one data byte.
   assign two_byte  = (status[6:4] != 3'b100) && (status[6:4] != 3'b101);

   assign msg_done = is_data && (((state == D1) && !two_byte) || (state == D2));
   assign msg_dat  = {status[6:4], status[3:0],
                      (state == D1) ? data[6:0] : d1_q,
                      (state == D2) ? data[6:0] : 7'd0};
   assign accept   = msg_done && CH_MASK[status[3:0]];

   midi_msg_fifo #(.W(21), .DEPTH(DEPTH)) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .wr_vld (accept),
      .wr_rdy (fifo_rdy),
      .wr_dat (msg_dat),
      .rd_vld (m_valid),
      .rd_rdy (m_ready),
      .rd_dat (head_dat),
      .count  (fifo_count)
   );

   assign {m_type, m_channel, m_data1, m_data2} = head_dat;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         status   <= 8'h00;
         d1_q     <= 7'd0;
         skip_cnt <= 2'd0;
         rst_cmd  <= 1'b0;
         drop_cnt <= '0;
      end else begin
         rst_cmd <= valid_byte && (data == 8'hFF);

         if (accept && !fifo_rdy && (drop_cnt != {CNT_W{1'b1}}))
            drop_cnt <= drop_cnt + 1'b1;

         // Real-time bytes fall through untouched: no state or status change.
         if (is_status) begin
            if ((state == SYSEX) && (data == 8'hF7)) begin
               status <= 8'h00;
               state  <= IDLE;
            end else if (data[7:4] != 4'hF) begin
               // Channel status from any state abandons a partial message.
               status <= data;
               state  <= D1;
            end else begin
               status <= 8'h00;
               case (data[3:0])
                  4'h0: state <= SYSEX;
                  4'h1, 4'h3: begin
                     state    <= SKIP;
                     skip_cnt <= 2'd1;
                  end
                  4'h2: begin
                     state    <= SKIP;
                     skip_cnt <= 2'd2;
                  end
                  default: state <= IDLE;
               endcase
            end
         end else if (is_data) begin
            case (state)
               D1: begin
                  if (two_byte) begin
                     d1_q  <= data[6:0];
                     state <= D2;
                  end else begin
                     state <= AFTER_MSG;
                  end
               end
               D2:    state  <= AFTER_MSG;
               SYSEX: status <= 8'h00;
               SKIP: begin
                  if (skip_cnt <= 2'd1) state <= IDLE;
                  skip_cnt <= skip_cnt - 1'b1;
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_midi_msg_decoder.sv
module tb_midi_msg_decoder;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       valid_byte = 1'b0;
   logic [7:0] data = 8'h00;
   logic       m_ready = 1'b0;
   logic       dm_ready = 1'b0;

   logic       m_valid, rst_cmd;
   logic [2:0] m_type;
   logic [3:0] m_channel;
   logic [6:0] m_data1, m_data2;
   logic [3:0] fifo_count;
   logic [7:0] drop_cnt;

   logic       dm_valid, dm_rst_cmd;
   logic [2:0] dm_type;
   logic [3:0] dm_channel;
   logic [6:0] dm_data1, dm_data2;
   logic [3:0] dm_count;
   logic [7:0] dm_drop;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   midi_msg_decoder #(.DEPTH(8), .CH_MASK(16'hFFFF), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .valid_byte(valid_byte), .data(data),
      .m_valid(m_valid), .m_ready(m_ready), .m_type(m_type),
      .m_channel(m_channel), .m_data1(m_data1), .m_data2(m_data2),
      .fifo_count(fifo_count), .rst_cmd(rst_cmd), .drop_cnt(drop_cnt)
   );

   midi_msg_decoder #(.DEPTH(8), .CH_MASK(16'h0001), .CNT_W(8)) dut_m (
      .clk(clk), .rst(rst), .valid_byte(valid_byte), .data(data),
      .m_valid(dm_valid), .m_ready(dm_ready), .m_type(dm_type),
      .m_channel(dm_channel), .m_data1(dm_data1), .m_data2(dm_data2),
      .fifo_count(dm_count), .rst_cmd(dm_rst_cmd), .drop_cnt(dm_drop)
   );

   wire [21:0] head    = {m_valid, m_type, m_channel, m_data1, m_data2};
   wire [21:0] dm_head = {dm_valid, dm_type, dm_channel, dm_data1, dm_data2};

   // Drive-only helpers; all checking is done inline in the test tasks.
   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1; valid_byte = 1'b0; m_ready = 1'b0; dm_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Byte is sampled at the posedge in between; returns on the next negedge.
   task automatic send(input logic [7:0] b);
      @(negedge clk);
      valid_byte = 1'b1; data = b;
      @(negedge clk);
      valid_byte = 1'b0;
   endtask

   task automatic do_pop();
      m_ready = 1'b1;
      @(negedge clk);
      m_ready = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      vectors++;
      if ({m_valid, rst_cmd, fifo_count, drop_cnt} !== 14'd0) begin
         miscompares++;
         $display("FAIL reset_ctrl: got %0h expected 0", {m_valid, rst_cmd, fifo_count, drop_cnt});
      end
      vectors++;
      if (head !== 22'd0) begin
         miscompares++;
         $display("FAIL reset_fields: got %0h expected 0", head);
      end
   endtask

   task automatic test_note_on();
      apply_reset();
      m_ready = 1'b1;
      send(8'h90); send(8'h3C);
      @(negedge clk);
      valid_byte = 1'b1; data = 8'h64;
      vectors++;
      if (m_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL note_early: m_valid got %b expected 0", m_valid);
      end
      @(negedge clk);
      valid_byte = 1'b0;
      vectors++;
      if (head !== {1'b1, 3'd1, 4'd0, 7'h3C, 7'h64}) begin
         miscompares++;
         $display("FAIL note_head: got %h expected %h", head, {1'b1, 3'd1, 4'd0, 7'h3C, 7'h64});
      end
      @(negedge clk);
      m_ready = 1'b0;
      vectors++;
      if ({m_valid, fifo_count} !== 5'd0) begin
         miscompares++;
         $display("FAIL note_popped: got %h expected 0", {m_valid, fifo_count});
      end
   endtask

   task automatic test_realtime();
      apply_reset();
      send(8'h93); send(8'h3C); send(8'hF8); send(8'h64);
      vectors++;
      if (fifo_count !== 4'd1 || head !== {1'b1, 3'd1, 4'd3, 7'h3C, 7'h64}) begin
         miscompares++;
         $display("FAIL rt_f8: got cnt %0d head %h expected 1 %h", fifo_count, head, {1'b1, 3'd1, 4'd3, 7'h3C, 7'h64});
      end
      do_pop();
      send(8'h93); send(8'h3C); send(8'hFF);
      vectors++;
      if (rst_cmd !== 1'b1) begin
         miscompares++;
         $display("FAIL rst_cmd_pulse: got %b expected 1", rst_cmd);
      end
      send(8'h64);
      vectors++;
      if (rst_cmd !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_cmd_one_cycle: got %b expected 0", rst_cmd);
      end
      vectors++;
      if (fifo_count !== 4'd1 || head !== {1'b1, 3'd1, 4'd3, 7'h3C, 7'h64}) begin
         miscompares++;
         $display("FAIL rt_ff: got cnt %0d head %h expected 1 %h", fifo_count, head, {1'b1, 3'd1, 4'd3, 7'h3C, 7'h64});
      end
      do_pop();
   endtask

   task automatic test_running_status();
      logic [3:0] exp_cnt;
`ifdef MIDI_RUNNING_STATUS_EN
      exp_cnt = 4'd2;
`else
      exp_cnt = 4'd1;
`endif
      apply_reset();
      send(8'h90); send(8'h3C); send(8'h64); send(8'h40); send(8'h00);
      vectors++;
      if (fifo_count !== exp_cnt) begin
         miscompares++;
         $display("FAIL rs_count: got %0d expected %0d", fifo_count, exp_cnt);
      end
      vectors++;
      if (head !== {1'b1, 3'd1, 4'd0, 7'h3C, 7'h64}) begin
         miscompares++;
         $display("FAIL rs_first: got %h expected %h", head, {1'b1, 3'd1, 4'd0, 7'h3C, 7'h64});
      end
      do_pop();
      if (exp_cnt == 4'd2) begin
         vectors++;
         if (head !== {1'b1, 3'd1, 4'd0, 7'h40, 7'h00}) begin
            miscompares++;
            $display("FAIL rs_second: got %h expected %h", head, {1'b1, 3'd1, 4'd0, 7'h40, 7'h00});
         end
         do_pop();
      end
   endtask

   task automatic test_one_byte_sysex();
      apply_reset();
      send(8'hC5); send(8'h07);
      vectors++;
      if (head !== {1'b1, 3'd4, 4'd5, 7'h07, 7'h00}) begin
         miscompares++;
         $display("FAIL prog_change: got %h expected %h", head, {1'b1, 3'd4, 4'd5, 7'h07, 7'h00});
      end
      do_pop();
      apply_reset();
      send(8'hF0); send(8'h11); send(8'h22); send(8'hF7);
      send(8'h80); send(8'h30); send(8'h00);
      vectors++;
      if (fifo_count !== 4'd1 || head !== {1'b1, 3'd0, 4'd0, 7'h30, 7'h00}) begin
         miscompares++;
         $display("FAIL sysex_skip: got cnt %0d head %h expected 1 %h", fifo_count, head, {1'b1, 3'd0, 4'd0, 7'h30, 7'h00});
      end
      do_pop();
      // F2 swallows two data bytes, then a fresh channel message decodes.
      send(8'hF2); send(8'h01); send(8'h02); send(8'h03);
      send(8'hB1); send(8'h07); send(8'h7F);
      vectors++;
      if (fifo_count !== 4'd1 || head !== {1'b1, 3'd3, 4'd1, 7'h07, 7'h7F}) begin
         miscompares++;
         $display("FAIL songpos_skip: got cnt %0d head %h expected 1 %h", fifo_count, head, {1'b1, 3'd3, 4'd1, 7'h07, 7'h7F});
      end
      do_pop();
   endtask

   task automatic test_overflow();
      apply_reset();
      for (int i = 0; i < 10; i++) begin
         send(8'h90); send(8'(i)); send(8'h40);
      end
      vectors++;
      if (fifo_count !== 4'd8 || drop_cnt !== 8'd2) begin
         miscompares++;
         $display("FAIL overflow: got cnt %0d drops %0d expected 8 2", fifo_count, drop_cnt);
      end
      // Push into a full FIFO while popping: accepted, not dropped.
      send(8'h90); send(8'h50);
      @(negedge clk);
      valid_byte = 1'b1; data = 8'h40; m_ready = 1'b1;
      @(negedge clk);
      valid_byte = 1'b0; m_ready = 1'b0;
      vectors++;
      if (fifo_count !== 4'd8 || drop_cnt !== 8'd2) begin
         miscompares++;
         $display("FAIL full_push_pop: got cnt %0d drops %0d expected 8 2", fifo_count, drop_cnt);
      end
      for (int k = 1; k <= 8; k++) begin
         logic [6:0] exp_d1;
         exp_d1 = (k == 8) ? 7'h50 : 7'(k);
         vectors++;
         if (head !== {1'b1, 3'd1, 4'd0, exp_d1, 7'h40}) begin
            miscompares++;
            $display("FAIL drain_%0d: got %h expected %h", k, head, {1'b1, 3'd1, 4'd0, exp_d1, 7'h40});
         end
         do_pop();
      end
      vectors++;
      if (m_valid !== 1'b0 || fifo_count !== 4'd0) begin
         miscompares++;
         $display("FAIL drain_empty: got %b %0d expected 0 0", m_valid, fifo_count);
      end
      // Ready while empty must not move the pointers.
      do_pop();
      send(8'hE2); send(8'h01); send(8'h02);
      vectors++;
      if (fifo_count !== 4'd1 || head !== {1'b1, 3'd6, 4'd2, 7'h01, 7'h02}) begin
         miscompares++;
         $display("FAIL after_empty_pop: got cnt %0d head %h expected 1 %h", fifo_count, head, {1'b1, 3'd6, 4'd2, 7'h01, 7'h02});
      end
   endtask

   task automatic test_mask();
      apply_reset();
      send(8'h91); send(8'h3C); send(8'h64);
      vectors++;
      if (dm_count !== 4'd0 || fifo_count !== 4'd1) begin
         miscompares++;
         $display("FAIL mask_ch1: got masked %0d open %0d expected 0 1", dm_count, fifo_count);
      end
      send(8'h90); send(8'h3C); send(8'h64);
      vectors++;
      if (dm_head !== {1'b1, 3'd1, 4'd0, 7'h3C, 7'h64}) begin
         miscompares++;
         $display("FAIL mask_ch0: got %h expected %h", dm_head, {1'b1, 3'd1, 4'd0, 7'h3C, 7'h64});
      end
      apply_reset();
      send(8'h90); send(8'h3C);
      apply_reset();
      send(8'h64);
      vectors++;
      if (dm_valid !== 1'b0 || dm_count !== 4'd0 || m_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid_msg: got %b %0d %b expected 0 0 0", dm_valid, dm_count, m_valid);
      end
   endtask

   initial begin
      test_reset();
      test_note_on();
      test_realtime();
      test_running_status();
      test_one_byte_sysex();
      test_overflow();
      test_mask();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
